// File: rtl/mux_pkg.sv
// Shared constants and types for the N:1 stream multiplexer.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // Index width that never collapses to zero bits, even for tiny N.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr,
// wrapping modulo N, by rotating, priority-encoding and rotating back.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = clog2_min1(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] grant_idx,
    output logic            grant_vld
);

    logic [N-1:0] rotated;
    int           src;
    int           offset;
    int           winner;

    always_comb begin
        rotated = '0;
        src     = 0;
        offset  = 0;
        winner  = 0;

        // rotated[0] is the requester just after the pointer
        for (int k = 0; k < N; k++) begin
            src = int'(ptr) + 1 + k;
            if (src >= N) src = src - N;
            if (src >= N) src = src - N;
            rotated[k] = req[src];
        end

        grant_vld = |rotated;

        for (int k = N - 1; k >= 0; k--) begin
            if (rotated[k]) offset = k;
        end

        winner = int'(ptr) + 1 + offset;
        if (winner >= N) winner = winner - N;
        if (winner >= N) winner = winner - N;
        grant_idx = SELW'(winner);
    end

endmodule

// File: rtl/mux_nx1_stream.sv
// N:1 valid/ready stream multiplexer with a single registered output stage,
// selecting either by external sel or by an internal round-robin arbiter.
module mux_nx1_stream
    import mux_pkg::*;
#(
    parameter int   N    = 4,
    parameter int   W    = 8,
    parameter int   SELW = clog2_min1(N),
    parameter logic MODE = MODE_FIXED
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [SELW-1:0] sel,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SELW-1:0] cur_sel
);

    out_state_e      state;
    logic [SELW-1:0] rr_ptr;
    logic [SELW-1:0] rr_idx;
    logic            rr_vld;
    logic [SELW-1:0] ch;
    logic            ch_vld;
    logic            can_load;
    logic            ch_valid;
    logic [W-1:0]    ch_data;
    logic            accept;

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .grant_idx (rr_idx),
        .grant_vld (rr_vld)
    );

    assign out_valid = (state == OUT_FULL);
    assign can_load  = ~out_valid | out_ready;

    always_comb begin
        ch     = '0;
        ch_vld = 1'b0;
        if (MODE == MODE_RR) begin
            ch     = rr_idx;
            ch_vld = rr_vld;
        end else begin
            ch     = sel;
            ch_vld = (int'(sel) < N);
        end
    end

    // Only the chosen channel sees ready; out-of-range sel chooses nothing.
    always_comb begin
        in_ready = '0;
        ch_data  = '0;
        ch_valid = 1'b0;
        for (int c = 0; c < N; c++) begin
            if (ch_vld && (int'(ch) == c)) begin
                in_ready[c] = can_load;
                ch_data     = in_data[c*W +: W];
                ch_valid    = in_valid[c];
            end
        end
    end

    assign accept = ch_valid & can_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= OUT_EMPTY;
            out_data <= '0;
            cur_sel  <= '0;
            rr_ptr   <= SELW'(N - 1);
        end else if (accept) begin
            state    <= OUT_FULL;
            out_data <= ch_data;
            cur_sel  <= ch;
            if (MODE == MODE_RR) rr_ptr <= ch;
        end else if (out_ready) begin
            state <= OUT_EMPTY;
        end
    end

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Bench for mux_nx1_stream: four instances (4:1 fixed, 4:1 round-robin,
// 3:1 fixed, 2:1 one-bit fixed) checked against directed values and a queue-free model.
module tb_mux_nx1_stream;
    import mux_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] f4_in_data;  logic [3:0] f4_in_valid; logic [3:0] f4_in_ready;
    logic [1:0]  f4_sel;      logic [7:0] f4_out_data; logic f4_out_valid;
    logic        f4_out_ready; logic [1:0] f4_cur_sel;

    logic [31:0] r4_in_data;  logic [3:0] r4_in_valid; logic [3:0] r4_in_ready;
    logic [1:0]  r4_sel;      logic [7:0] r4_out_data; logic r4_out_valid;
    logic        r4_out_ready; logic [1:0] r4_cur_sel;

    logic [23:0] f3_in_data;  logic [2:0] f3_in_valid; logic [2:0] f3_in_ready;
    logic [1:0]  f3_sel;      logic [7:0] f3_out_data; logic f3_out_valid;
    logic        f3_out_ready; logic [1:0] f3_cur_sel;

    logic [1:0]  f2_in_data;  logic [1:0] f2_in_valid; logic [1:0] f2_in_ready;
    logic [0:0]  f2_sel;      logic [0:0] f2_out_data; logic f2_out_valid;
    logic        f2_out_ready; logic [0:0] f2_cur_sel;

    mux_nx1_stream #(.N(4), .W(8), .MODE(MODE_FIXED)) u_f4 (
        .clk(clk), .rst(rst), .in_data(f4_in_data), .in_valid(f4_in_valid),
        .in_ready(f4_in_ready), .sel(f4_sel), .out_data(f4_out_data),
        .out_valid(f4_out_valid), .out_ready(f4_out_ready), .cur_sel(f4_cur_sel));

    mux_nx1_stream #(.N(4), .W(8), .MODE(MODE_RR)) u_r4 (
        .clk(clk), .rst(rst), .in_data(r4_in_data), .in_valid(r4_in_valid),
        .in_ready(r4_in_ready), .sel(r4_sel), .out_data(r4_out_data),
        .out_valid(r4_out_valid), .out_ready(r4_out_ready), .cur_sel(r4_cur_sel));

    mux_nx1_stream #(.N(3), .W(8), .MODE(MODE_FIXED)) u_f3 (
        .clk(clk), .rst(rst), .in_data(f3_in_data), .in_valid(f3_in_valid),
        .in_ready(f3_in_ready), .sel(f3_sel), .out_data(f3_out_data),
        .out_valid(f3_out_valid), .out_ready(f3_out_ready), .cur_sel(f3_cur_sel));

    mux_nx1_stream #(.N(2), .W(1), .MODE(MODE_FIXED)) u_f2 (
        .clk(clk), .rst(rst), .in_data(f2_in_data), .in_valid(f2_in_valid),
        .in_ready(f2_in_ready), .sel(f2_sel), .out_data(f2_out_data),
        .out_valid(f2_out_valid), .out_ready(f2_out_ready), .cur_sel(f2_cur_sel));

    // Reference model state per instance: 0=f4, 1=r4, 2=f3, 3=f2.
    int m_n[4]     = '{4, 4, 3, 2};
    int m_w[4]     = '{8, 8, 8, 1};
    bit m_rr[4]    = '{1'b0, 1'b1, 1'b0, 1'b0};
    int m_valid[4];
    int m_data[4];
    int m_sel[4];
    int m_ptr[4];

    function automatic int pick(input int i, input int s, input logic [3:0] v);
        int c;
        if (!m_rr[i]) return (s < m_n[i]) ? s : -1;
        for (int k = 1; k <= m_n[i]; k++) begin
            c = (m_ptr[i] + k) % m_n[i];
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready(input int i, input int s, input logic [3:0] v,
                                             input logic ordy);
        int c;
        logic [3:0] r;
        r = 4'b0000;
        c = pick(i, s, v);
        if (c >= 0) r[c] = (m_valid[i] == 0) || ordy;
        return r;
    endfunction

    task automatic model_reset_all();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 0;
            m_data[i]  = 0;
            m_sel[i]   = 0;
            m_ptr[i]   = m_n[i] - 1;
        end
    endtask

    task automatic model_edge(input int i, input int s, input logic [3:0] v,
                              input logic [31:0] d, input logic ordy);
        int c;
        bit can_load;
        c = pick(i, s, v);
        can_load = (m_valid[i] == 0) || ordy;
        if (c >= 0 && v[c] && can_load) begin
            m_data[i]  = int'((d >> (c * m_w[i])) & ((32'd1 << m_w[i]) - 32'd1));
            m_valid[i] = 1;
            m_sel[i]   = c;
            if (m_rr[i]) m_ptr[i] = c;
        end else if (ordy) begin
            m_valid[i] = 0;
        end
    endtask

    initial begin
        model_reset_all();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_reset_all();
            end else begin
                model_edge(0, int'(f4_sel), f4_in_valid, f4_in_data, f4_out_ready);
                model_edge(1, int'(r4_sel), r4_in_valid, r4_in_data, r4_out_ready);
                model_edge(2, int'(f3_sel), {1'b0, f3_in_valid}, {8'h00, f3_in_data}, f3_out_ready);
                model_edge(3, int'(f2_sel), {2'b00, f2_in_valid}, {30'h0, f2_in_data}, f2_out_ready);
            end
        end
    end

    task automatic test_reset();
        total++;
        if ({f4_out_valid, f4_out_data, f4_cur_sel} !== 11'h000) begin
            bad++; $display("[TB] FAIL reset_f4: got %h expected 000", {f4_out_valid, f4_out_data, f4_cur_sel});
        end
        total++;
        if ({r4_out_valid, r4_out_data, r4_cur_sel, f3_out_valid, f3_out_data, f3_cur_sel} !== 22'h0) begin
            bad++; $display("[TB] FAIL reset_r4_f3: got %h expected 0",
                            {r4_out_valid, r4_out_data, r4_cur_sel, f3_out_valid, f3_out_data, f3_cur_sel});
        end
        // Fill the fixed 4:1 output, then assert reset between clock edges.
        f4_sel = 2'd2; f4_in_data = 32'h11A52233; f4_in_valid = 4'b0100; f4_out_ready = 1'b1;
        @(posedge clk); #1;
        f4_in_valid = 4'b0000; f4_out_ready = 1'b0;
        total++;
        if ({f4_out_valid, f4_out_data} !== 9'h1A5) begin
            bad++; $display("[TB] FAIL reset_prefill: got %h expected 1a5", {f4_out_valid, f4_out_data});
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({f4_out_valid, f4_out_data, f4_cur_sel} !== 11'h000) begin
            bad++; $display("[TB] FAIL reset_async: got %h expected 000", {f4_out_valid, f4_out_data, f4_cur_sel});
        end
        #2 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_fixed_basic();
        f4_sel = 2'd2; f4_in_data = 32'h11A52233; f4_in_valid = 4'b0100; f4_out_ready = 1'b1;
        #3;
        total++;
        if (f4_in_ready !== 4'b0100) begin
            bad++; $display("[TB] FAIL fixed_ready: got %b expected 0100", f4_in_ready);
        end
        @(posedge clk); #1;
        total++;
        if ({f4_out_valid, f4_out_data, f4_cur_sel} !== {1'b1, 8'hA5, 2'd2}) begin
            bad++; $display("[TB] FAIL fixed_out: got %h expected %h",
                            {f4_out_valid, f4_out_data, f4_cur_sel}, {1'b1, 8'hA5, 2'd2});
        end
    endtask

    task automatic test_backpressure();
        f4_out_ready = 1'b0; f4_sel = 2'd1; f4_in_data = 32'h11A53C33; f4_in_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            #3;
            total++;
            if (f4_in_ready !== 4'b0000) begin
                bad++; $display("[TB] FAIL stall_ready[%0d]: got %b expected 0000", k, f4_in_ready);
            end
            @(posedge clk); #1;
            total++;
            if ({f4_out_valid, f4_out_data, f4_cur_sel} !== {1'b1, 8'hA5, 2'd2}) begin
                bad++; $display("[TB] FAIL stall_hold[%0d]: got %h expected %h", k,
                                {f4_out_valid, f4_out_data, f4_cur_sel}, {1'b1, 8'hA5, 2'd2});
            end
        end
        f4_out_ready = 1'b1;
        #3;
        total++;
        if (f4_in_ready !== 4'b0010) begin
            bad++; $display("[TB] FAIL release_ready: got %b expected 0010", f4_in_ready);
        end
        @(posedge clk); #1;
        f4_in_valid = 4'b0000;
        total++;
        if ({f4_out_valid, f4_out_data, f4_cur_sel} !== {1'b1, 8'h3C, 2'd1}) begin
            bad++; $display("[TB] FAIL release_out: got %h expected %h",
                            {f4_out_valid, f4_out_data, f4_cur_sel}, {1'b1, 8'h3C, 2'd1});
        end
        @(posedge clk); #1;
        total++;
        if ({f4_out_valid, f4_out_data, f4_cur_sel} !== {1'b0, 8'h3C, 2'd1}) begin
            bad++; $display("[TB] FAIL drain_out: got %h expected %h",
                            {f4_out_valid, f4_out_data, f4_cur_sel}, {1'b0, 8'h3C, 2'd1});
        end
    endtask

    task automatic test_rr_all();
        logic [7:0] want;
        r4_in_data = $urandom; r4_in_valid = 4'b1111; r4_out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #3;
            total++;
            if (r4_in_ready !== 4'(1 << (k % 4))) begin
                bad++; $display("[TB] FAIL rr_all_ready[%0d]: got %b expected %b", k, r4_in_ready, 4'(1 << (k % 4)));
            end
            want = 8'((r4_in_data >> (8 * (k % 4))) & 32'hFF);
            @(posedge clk); #1;
            total++;
            if ({r4_out_valid, r4_cur_sel, r4_out_data} !== {1'b1, 2'(k % 4), want}) begin
                bad++; $display("[TB] FAIL rr_all_seq[%0d]: got %h expected %h", k,
                                {r4_out_valid, r4_cur_sel, r4_out_data}, {1'b1, 2'(k % 4), want});
            end
            r4_in_data = $urandom;
        end
    endtask

    task automatic test_rr_skip();
        int exp_seq[7] = '{1, 3, 1, 3, 1, 1, 1};
        r4_in_valid = 4'b1010; r4_out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k == 4) r4_in_valid = 4'b0010;
            @(posedge clk); #1;
            total++;
            if ({r4_out_valid, r4_cur_sel} !== {1'b1, 2'(exp_seq[k])}) begin
                bad++; $display("[TB] FAIL rr_skip[%0d]: got %h expected %h", k,
                                {r4_out_valid, r4_cur_sel}, {1'b1, 2'(exp_seq[k])});
            end
        end
        r4_in_valid = 4'b0000;
        @(posedge clk); #1;
    endtask

    task automatic test_out_of_range();
        f3_sel = 2'd1; f3_in_data = 24'h5AC317; f3_in_valid = 3'b010; f3_out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({f3_out_valid, f3_out_data, f3_cur_sel} !== {1'b1, 8'hC3, 2'd1}) begin
            bad++; $display("[TB] FAIL oor_load: got %h expected %h",
                            {f3_out_valid, f3_out_data, f3_cur_sel}, {1'b1, 8'hC3, 2'd1});
        end
        f3_sel = 2'd3; f3_in_valid = 3'b111; f3_out_ready = 1'b0;
        #3;
        total++;
        if (f3_in_ready !== 3'b000) begin
            bad++; $display("[TB] FAIL oor_ready_stall: got %b expected 000", f3_in_ready);
        end
        @(posedge clk); #1;
        total++;
        if ({f3_out_valid, f3_out_data} !== {1'b1, 8'hC3}) begin
            bad++; $display("[TB] FAIL oor_hold: got %h expected %h", {f3_out_valid, f3_out_data}, {1'b1, 8'hC3});
        end
        f3_out_ready = 1'b1;
        #3;
        total++;
        if (f3_in_ready !== 3'b000) begin
            bad++; $display("[TB] FAIL oor_ready_drain: got %b expected 000", f3_in_ready);
        end
        @(posedge clk); #1;
        total++;
        if (f3_out_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL oor_drain: got %b expected 0", f3_out_valid);
        end
        f3_in_valid = 3'b000; f3_sel = 2'd0;
    endtask

    task automatic test_exhaustive_2x1();
        logic [2:0] combo;
        logic       want;
        f2_in_valid = 2'b11; f2_out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            combo = 3'(k);
            f2_in_data = combo[1:0];
            f2_sel = combo[2:2];
            want = combo[2] ? combo[1] : combo[0];
            @(posedge clk); #1;
            total++;
            if ({f2_out_valid, f2_out_data, f2_cur_sel} !== {1'b1, want, combo[2]}) begin
                bad++; $display("[TB] FAIL mux2_truth[%0d]: got %b expected %b", k,
                                {f2_out_valid, f2_out_data, f2_cur_sel}, {1'b1, want, combo[2]});
            end
        end
        f2_in_valid = 2'b00;
    endtask

    task automatic test_random();
        logic [3:0] er;
        for (int k = 0; k < 300; k++) begin
            f4_in_data = $urandom; f4_in_valid = 4'($urandom); f4_sel = 2'($urandom);
            f4_out_ready = ($urandom_range(0, 3) != 0);
            r4_in_data = $urandom; r4_in_valid = 4'($urandom);
            r4_out_ready = ($urandom_range(0, 3) != 0);
            f3_in_data = 24'($urandom); f3_in_valid = 3'($urandom); f3_sel = 2'($urandom);
            f3_out_ready = ($urandom_range(0, 3) != 0);
            #3;
            er = exp_ready(0, int'(f4_sel), f4_in_valid, f4_out_ready);
            total++;
            if (f4_in_ready !== er) begin
                bad++; $display("[TB] FAIL rand_f4_ready[%0d]: got %b expected %b", k, f4_in_ready, er);
            end
            er = exp_ready(1, 0, r4_in_valid, r4_out_ready);
            total++;
            if (r4_in_ready !== er) begin
                bad++; $display("[TB] FAIL rand_r4_ready[%0d]: got %b expected %b", k, r4_in_ready, er);
            end
            er = exp_ready(2, int'(f3_sel), {1'b0, f3_in_valid}, f3_out_ready);
            total++;
            if ({1'b0, f3_in_ready} !== er) begin
                bad++; $display("[TB] FAIL rand_f3_ready[%0d]: got %b expected %b", k, f3_in_ready, er);
            end
            @(posedge clk); #1;
            total++;
            if ({f4_out_valid, f4_out_data, f4_cur_sel} !== {m_valid[0] != 0, 8'(m_data[0]), 2'(m_sel[0])}) begin
                bad++; $display("[TB] FAIL rand_f4_out[%0d]: got %h expected %h", k,
                                {f4_out_valid, f4_out_data, f4_cur_sel}, {m_valid[0] != 0, 8'(m_data[0]), 2'(m_sel[0])});
            end
            total++;
            if ({r4_out_valid, r4_out_data, r4_cur_sel} !== {m_valid[1] != 0, 8'(m_data[1]), 2'(m_sel[1])}) begin
                bad++; $display("[TB] FAIL rand_r4_out[%0d]: got %h expected %h", k,
                                {r4_out_valid, r4_out_data, r4_cur_sel}, {m_valid[1] != 0, 8'(m_data[1]), 2'(m_sel[1])});
            end
            total++;
            if ({f3_out_valid, f3_out_data, f3_cur_sel} !== {m_valid[2] != 0, 8'(m_data[2]), 2'(m_sel[2])}) begin
                bad++; $display("[TB] FAIL rand_f3_out[%0d]: got %h expected %h", k,
                                {f3_out_valid, f3_out_data, f3_cur_sel}, {m_valid[2] != 0, 8'(m_data[2]), 2'(m_sel[2])});
            end
        end
    endtask

    initial begin
        f4_in_data = '0; f4_in_valid = '0; f4_sel = '0; f4_out_ready = 1'b0;
        r4_in_data = '0; r4_in_valid = '0; r4_sel = '0; r4_out_ready = 1'b0;
        f3_in_data = '0; f3_in_valid = '0; f3_sel = '0; f3_out_ready = 1'b0;
        f2_in_data = '0; f2_in_valid = '0; f2_sel = '0; f2_out_ready = 1'b0;
        #7 rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_fixed_basic();
        test_backpressure();
        test_rr_all();
        test_rr_skip();
        test_out_of_range();
        test_exhaustive_2x1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
